// File: rtl/deskew_sequencer.sv
// Supervisory controller for the per-lane deskew FSM: waits for AM lock on all lanes,
// resyncs, supervises deskew, confirms alignment over several marker periods, retries or fails.
module deskew_sequencer #(
  parameter int N_LANES        = 20,
  parameter int DESKEW_TIMEOUT = 16384,
  parameter int NB_TIMER       = $clog2(DESKEW_TIMEOUT),
  parameter int N_CONFIRM      = 3,
  parameter int NB_CONFIRM     = $clog2(N_CONFIRM + 1),
  parameter int MAX_RETRY      = 7,
  parameter int NB_RETRY       = $clog2(MAX_RETRY + 1)
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic [N_LANES-1:0]  i_am_lock,
  input  logic                i_deskew_done,
  input  logic                i_invalid_skew,
  input  logic [N_LANES-1:0]  i_aligned_am,
  output logic                o_resync,
  output logic                o_deskew_enable,
  output logic                o_align_status,
  output logic                o_fail,
  output logic [NB_RETRY-1:0] o_retry_count,
  output logic [2:0]          o_state
);

  localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
  localparam logic [2:0] ST_RESYNC    = 3'd1;
  localparam logic [2:0] ST_DESKEW    = 3'd2;
  localparam logic [2:0] ST_CONFIRM   = 3'd3;
  localparam logic [2:0] ST_ALIGNED   = 3'd4;
  localparam logic [2:0] ST_FAILED    = 3'd5;

  localparam logic [NB_TIMER-1:0]   TIMER_LAST   = NB_TIMER'(DESKEW_TIMEOUT - 1);
  localparam logic [NB_CONFIRM-1:0] CONFIRM_GOAL = NB_CONFIRM'(N_CONFIRM);
  localparam logic [NB_RETRY-1:0]   RETRY_LIMIT  = NB_RETRY'(MAX_RETRY);

  logic [2:0]            state_r;
  logic [2:0]            state_pre_s;
  logic [2:0]            state_next_s;
  logic [NB_TIMER-1:0]   timer_r;
  logic [NB_TIMER-1:0]   timer_pre_s;
  logic [NB_TIMER-1:0]   timer_next_s;
  logic [NB_CONFIRM-1:0] confirm_r;
  logic [NB_CONFIRM-1:0] confirm_pre_s;
  logic [NB_CONFIRM-1:0] confirm_next_s;
  logic [NB_CONFIRM-1:0] confirm_inc_s;
  logic [NB_RETRY-1:0]   retry_r;
  logic [NB_RETRY-1:0]   retry_pre_s;
  logic [NB_RETRY-1:0]   retry_next_s;
  logic                  retry_req_s;
  logic                  qual_s;
  logic                  all_lock_s;
  logic                  am_full_s;
  logic                  am_partial_s;
  logic                  timeout_s;
  logic                  link_bad_s;
  logic                  resync_s;
  logic                  deskew_enable_s;
  logic                  align_status_s;
  logic                  fail_s;
  logic                  resync_r;
  logic                  deskew_enable_r;
  logic                  align_status_r;
  logic                  fail_r;

  assign qual_s        = i_enable & i_valid;
  assign all_lock_s    = &i_am_lock;
  assign am_full_s     = &i_aligned_am;
  assign am_partial_s  = (|i_aligned_am) & ~am_full_s;
  assign timeout_s     = (timer_r == TIMER_LAST);
  assign link_bad_s    = ~i_deskew_done | i_invalid_skew | am_partial_s;
  assign confirm_inc_s = confirm_r + NB_CONFIRM'(1);

  // State register and supervision counters
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r   <= ST_WAIT_LOCK;
      timer_r   <= {NB_TIMER{1'b0}};
      confirm_r <= {NB_CONFIRM{1'b0}};
      retry_r   <= {NB_RETRY{1'b0}};
    end else begin
      state_r   <= state_next_s;
      timer_r   <= timer_next_s;
      confirm_r <= confirm_next_s;
      retry_r   <= retry_next_s;
    end
  end

  // Next-state decision; lock loss overrides every per-state event
  always_comb begin
    state_pre_s   = state_r;
    timer_pre_s   = timer_r;
    confirm_pre_s = confirm_r;
    retry_pre_s   = retry_r;
    retry_req_s   = 1'b0;
    if (!qual_s) begin
      state_pre_s = state_r;
    end else if ((state_r != ST_WAIT_LOCK) && !all_lock_s) begin
      state_pre_s = ST_WAIT_LOCK;
      retry_pre_s = {NB_RETRY{1'b0}};
    end else begin
      case (state_r)
        ST_WAIT_LOCK: begin
          if (all_lock_s) begin
            state_pre_s = ST_RESYNC;
          end else begin
            state_pre_s = ST_WAIT_LOCK;
          end
        end
        ST_RESYNC: state_pre_s = ST_DESKEW;
        ST_DESKEW: begin
          if (i_invalid_skew) begin
            retry_req_s = 1'b1;
          end else if (i_deskew_done) begin
            state_pre_s = ST_CONFIRM;
          end else if (timeout_s) begin
            retry_req_s = 1'b1;
          end else begin
            timer_pre_s = timer_r + NB_TIMER'(1);
          end
        end
        ST_CONFIRM: begin
          if (link_bad_s) begin
            retry_req_s = 1'b1;
          end else if (am_full_s) begin
            timer_pre_s = {NB_TIMER{1'b0}};
            if (confirm_inc_s == CONFIRM_GOAL) begin
              state_pre_s = ST_ALIGNED;
              retry_pre_s = {NB_RETRY{1'b0}};
            end else begin
              confirm_pre_s = confirm_inc_s;
            end
          end else if (timeout_s) begin
            retry_req_s = 1'b1;
          end else begin
            timer_pre_s = timer_r + NB_TIMER'(1);
          end
        end
        ST_ALIGNED: begin
          if (link_bad_s) begin
            retry_req_s = 1'b1;
          end else if (am_full_s) begin
            timer_pre_s = {NB_TIMER{1'b0}};
          end else if (timeout_s) begin
            retry_req_s = 1'b1;
          end else begin
            timer_pre_s = timer_r + NB_TIMER'(1);
          end
        end
        ST_FAILED: state_pre_s = ST_FAILED;
        default:   state_pre_s = ST_WAIT_LOCK;
      endcase
    end
  end

  // Retry resolution; any state change restarts the timer and confirm count
  assign state_next_s   = retry_req_s ? ((retry_r == RETRY_LIMIT) ? ST_FAILED : ST_RESYNC) : state_pre_s;
  assign retry_next_s   = (retry_req_s && (retry_r != RETRY_LIMIT)) ? (retry_r + NB_RETRY'(1)) : retry_pre_s;
  assign timer_next_s   = (state_next_s != state_r) ? {NB_TIMER{1'b0}} : timer_pre_s;
  assign confirm_next_s = (state_next_s != state_r) ? {NB_CONFIRM{1'b0}} : confirm_pre_s;

  // Moore output decode of the upcoming state, registered below
  always_comb begin
    resync_s        = 1'b0;
    deskew_enable_s = 1'b0;
    align_status_s  = 1'b0;
    fail_s          = 1'b0;
    case (state_next_s)
      ST_RESYNC:  resync_s = 1'b1;
      ST_DESKEW:  deskew_enable_s = 1'b1;
      ST_CONFIRM: deskew_enable_s = 1'b1;
      ST_ALIGNED: begin
        deskew_enable_s = 1'b1;
        align_status_s  = 1'b1;
      end
      ST_FAILED:  fail_s = 1'b1;
      default:    resync_s = 1'b0;
    endcase
  end

  // Output registers, cleared asynchronously with the state
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      resync_r        <= 1'b0;
      deskew_enable_r <= 1'b0;
      align_status_r  <= 1'b0;
      fail_r          <= 1'b0;
    end else begin
      resync_r        <= resync_s;
      deskew_enable_r <= deskew_enable_s;
      align_status_r  <= align_status_s;
      fail_r          <= fail_s;
    end
  end

  assign o_resync        = resync_r;
  assign o_deskew_enable = deskew_enable_r;
  assign o_align_status  = align_status_r;
  assign o_fail          = fail_r;
  assign o_retry_count   = retry_r;
  assign o_state         = state_r;

endmodule

// File: tb/tb_deskew_sequencer.sv
// Self-checking bench for deskew_sequencer: directed scenarios plus randomized traffic,
// compared every cycle against an event-level reference model.
module tb_deskew_sequencer;
  localparam int LANES = 4;
  localparam int TMO   = 64;
  localparam int NCONF = 3;
  localparam int MAXR  = 2;

  logic       i_clock = 1'b0;
  logic       i_reset_n = 1'b1;
  logic       i_enable = 1'b1;
  logic       i_valid = 1'b1;
  logic [3:0] i_am_lock = 4'h0;
  logic       i_deskew_done = 1'b0;
  logic       i_invalid_skew = 1'b0;
  logic [3:0] i_aligned_am = 4'h0;
  logic       o_resync;
  logic       o_deskew_enable;
  logic       o_align_status;
  logic       o_fail;
  logic [1:0] o_retry_count;
  logic [2:0] o_state;

  int n_checks = 0;
  int n_pass = 0;
  // reference model: 0 wait-lock, 1 resync, 2 deskew, 3 confirm, 4 aligned, 5 failed
  int m_state = 0;
  int m_timer = 0;
  int m_conf = 0;
  int m_retry = 0;

  deskew_sequencer #(
    .N_LANES(LANES), .DESKEW_TIMEOUT(TMO), .N_CONFIRM(NCONF), .MAX_RETRY(MAXR)
  ) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_valid(i_valid),
    .i_am_lock(i_am_lock), .i_deskew_done(i_deskew_done), .i_invalid_skew(i_invalid_skew),
    .i_aligned_am(i_aligned_am), .o_resync(o_resync), .o_deskew_enable(o_deskew_enable),
    .o_align_status(o_align_status), .o_fail(o_fail), .o_retry_count(o_retry_count),
    .o_state(o_state)
  );

  always #5 i_clock = ~i_clock;

  task automatic check_value(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int dut_vec();
    return int'(o_state) * 64 + int'(o_resync) * 32 + int'(o_deskew_enable) * 16 +
           int'(o_align_status) * 8 + int'(o_fail) * 4 + int'(o_retry_count);
  endfunction

  function automatic int model_vec();
    return m_state * 64 + int'(m_state == 1) * 32 + int'(m_state >= 2 && m_state <= 4) * 16 +
           int'(m_state == 4) * 8 + int'(m_state == 5) * 4 + m_retry;
  endfunction

  task automatic m_goto(input int s);
    m_state = s;
    m_timer = 0;
    m_conf  = 0;
  endtask

  task automatic m_fail_attempt();
    if (m_retry == MAXR) m_goto(5);
    else begin
      m_retry++;
      m_goto(1);
    end
  endtask

  task automatic model_step();
    bit lock, full, partial;
    if (!(i_enable && i_valid)) return;
    lock    = (i_am_lock == 4'hF);
    full    = (i_aligned_am == 4'hF);
    partial = (i_aligned_am != 4'h0) && !full;
    if (m_state != 0 && !lock) begin
      m_goto(0);
      m_retry = 0;
      return;
    end
    case (m_state)
      0: if (lock) m_goto(1);
      1: m_goto(2);
      2: begin
        if (i_invalid_skew) m_fail_attempt();
        else if (i_deskew_done) m_goto(3);
        else if (m_timer == TMO - 1) m_fail_attempt();
        else m_timer++;
      end
      3, 4: begin
        if (!i_deskew_done || i_invalid_skew || partial) m_fail_attempt();
        else if (full) begin
          m_timer = 0;
          if (m_state == 3) begin
            m_conf++;
            if (m_conf == NCONF) begin
              m_goto(4);
              m_retry = 0;
            end
          end
        end
        else if (m_timer == TMO - 1) m_fail_attempt();
        else m_timer++;
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge i_clock);
    if (i_reset_n) model_step();
    #1;
    check_value("cycle", dut_vec(), model_vec());
  endtask

  task automatic marker(input logic [3:0] am);
    i_aligned_am = am;
    tick();
    i_aligned_am = 4'h0;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    m_state = 0; m_timer = 0; m_conf = 0; m_retry = 0;
    #2;
    check_value("reset_outputs", dut_vec(), 0);
    @(negedge i_clock);
    i_reset_n = 1'b1;
  endtask

  initial begin
    int r;
    do_reset();

    // nominal bring-up
    i_am_lock = 4'hF;
    tick();
    check_value("nom_resync", int'(o_resync), 1);
    tick();
    check_value("nom_resync_once", int'(o_resync), 0);
    check_value("nom_deskew_en", int'(o_deskew_enable), 1);
    repeat (9) tick();
    i_deskew_done = 1'b1;
    tick();
    check_value("nom_confirm_state", int'(o_state), 3);
    for (int k = 0; k < 3; k++) begin
      repeat (19) tick();
      check_value("nom_not_yet_aligned", int'(o_align_status), 0);
      marker(4'hF);
    end
    check_value("nom_aligned", int'(o_align_status), 1);
    check_value("nom_retry", int'(o_retry_count), 0);

    // invalid skew retries then failure
    do_reset();
    i_deskew_done = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 1) tick();
      i_invalid_skew = 1'b1;
      tick();
      i_invalid_skew = 1'b0;
      if (k < 3) check_value("inv_retry_count", int'(o_retry_count), k);
    end
    check_value("inv_fail", int'(o_fail), 1);
    check_value("inv_fail_state", int'(o_state), 5);
    tick();
    check_value("inv_fail_hold", int'(o_fail), 1);
    i_am_lock = 4'b1011;
    tick();
    check_value("inv_lockloss_state", int'(o_state), 0);
    check_value("inv_lockloss_fail", int'(o_fail), 0);

    // deskew timeout
    i_am_lock = 4'hF;
    tick();
    tick();
    repeat (63) tick();
    check_value("tmo_not_early", int'(o_resync), 0);
    tick();
    check_value("tmo_resync", int'(o_resync), 1);
    check_value("tmo_retry", int'(o_retry_count), 1);

    // partial marker while aligned
    tick();
    i_deskew_done = 1'b1;
    tick();
    repeat (3) begin
      marker(4'hF);
      tick();
    end
    check_value("part_aligned", int'(o_align_status), 1);
    marker(4'b1011);
    check_value("part_align_drop", int'(o_align_status), 0);
    check_value("part_resync", int'(o_resync), 1);
    check_value("part_retry", int'(o_retry_count), 1);

    // stall in RESYNC, then async reset mid-CONFIRM
    i_valid = 1'b0;
    repeat (5) begin
      tick();
      check_value("stall_resync", int'(o_resync), 1);
      check_value("stall_state", int'(o_state), 1);
    end
    i_valid = 1'b1;
    tick();
    tick();
    tick();
    check_value("rst_pre_confirm", int'(o_state), 3);
    do_reset();

    // lock loss beats a full marker in CONFIRM
    tick();
    tick();
    tick();
    marker(4'hF);
    i_am_lock = 4'b1110;
    marker(4'hF);
    check_value("ll_state", int'(o_state), 0);
    i_am_lock = 4'hF;
    tick();
    tick();
    tick();
    marker(4'hF);
    marker(4'hF);
    check_value("ll_no_carry", int'(o_align_status), 0);
    marker(4'hF);
    check_value("ll_realign", int'(o_align_status), 1);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      i_enable       = ($urandom_range(0, 99) < 95);
      i_valid        = ($urandom_range(0, 99) < 90);
      i_am_lock      = ($urandom_range(0, 99) < 3) ? 4'($urandom_range(0, 15)) : 4'hF;
      i_invalid_skew = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 3) i_deskew_done = ~i_deskew_done;
      r = $urandom_range(0, 99);
      if (r < 10) i_aligned_am = 4'hF;
      else if (r < 12) i_aligned_am = 4'($urandom_range(1, 14));
      else i_aligned_am = 4'h0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
